// File: rtl/npu_host_pkg.sv
// Shared types and constants for the NPU host-side bus sequencer.
package npu_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_GAP  = 3'd4,
    S_RESP = 3'd5
  } state_e;

  // Window select values carried in addr[14:12]
  localparam logic [2:0] SEL_IMG    = 3'd1;
  localparam logic [2:0] SEL_W      = 3'd2;
  localparam logic [2:0] SEL_FCN    = 3'd3;
  localparam logic [2:0] SEL_CTRL   = 3'd4;
  localparam logic [2:0] SEL_DONE   = 3'd5;
  localparam logic [2:0] SEL_RESULT = 3'd6;
  localparam logic [2:0] SEL_VALID  = 3'd7;

  // Bit positions inside the control window word
  localparam int TRIGGER  = 0;
  localparam int NEXT     = 1;
  localparam int PE_CLR   = 2;
  localparam int IMG_CLR  = 3;
  localparam int W_CLR    = 4;
  localparam int PACK_CLR = 5;

endpackage

// File: rtl/npu_host_seq.sv
// Host bus master turning WRITE/READ/POLL commands into NPU port cycles.
// Optional poll timeout is enabled by defining NPU_HOST_POLL_TIMEOUT_EN.
module npu_host_seq
  import npu_host_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic [2:0]        dbg_state
);

  // Handshake: a transfer happens on a clk edge where valid && ready are both
  // high; the producer holds its payload stable until that edge.

  if (POLL_MAX < 1) begin : g_bad_poll_max
    $error("POLL_MAX must be at least 1");
  end

  state_e            state, state_nx;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              hit;
  logic              mask_zero;
  logic              timeout;
  logic              cap_done;
  logic              bus_nx;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  op_e               op_in;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign dbg_state = state;

  // Reserved opcode 3 behaves as a plain read
  assign op_in = (cmd_op == 2'd0) ? OP_WRITE :
                 (cmd_op == 2'd2) ? OP_POLL  : OP_READ;

  assign hit       = |(douta & data_q);
  assign mask_zero = (data_q == '0);
  assign cap_done  = (op_q != OP_POLL) || mask_zero || hit || timeout;

  // Address/data come straight from the command on the accept edge
  assign bus_addr = (state == S_IDLE) ? cmd_addr : addr_q;
  assign bus_data = (state == S_IDLE) ? cmd_data : data_q;
  assign bus_nx   = (state_nx == S_WR) || (state_nx == S_RD);

`ifdef NPU_HOST_POLL_TIMEOUT_EN
  localparam int CNT_W = $clog2(POLL_MAX + 1);
  logic [CNT_W-1:0] poll_cnt;

  // The read just captured is the POLL_MAX-th one without a match
  assign timeout = (poll_cnt >= CNT_W'(POLL_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (state == S_CAP) begin
        if (cap_done) begin
          rsp_err <= (op_q == OP_POLL) && !mask_zero && !hit;
        end else if (poll_cnt != CNT_W'(POLL_MAX)) begin
          poll_cnt <= poll_cnt + 1'b1;
        end
      end else if (state == S_RESP && rsp_ready) begin
        poll_cnt <= '0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = (op_in == OP_WRITE) ? S_WR : S_RD;
      S_WR:   state_nx = (addr_q[14:12] == SEL_CTRL) ? S_GAP : S_IDLE;
      S_GAP:  state_nx = S_IDLE;
      S_RD:   state_nx = S_CAP;
      S_CAP:  state_nx = cap_done ? S_RESP : S_RD;
      S_RESP: if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      data_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      ena       <= 1'b0;
      wea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= op_in;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end
      // Bus strobes are launched for the cycle the FSM spends in WR/RD
      ena <= bus_nx;
      wea <= (state_nx == S_WR);
      if (bus_nx) begin
        addra <= bus_addr;
        dina  <= bus_data;
      end
      if (state == S_CAP && cap_done) begin
        rsp_valid <= 1'b1;
        rsp_data  <= douta;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_npu_host_seq.sv
// Directed bench for npu_host_seq with a registered-read NPU bus model.
module tb_npu_host_seq;

`ifdef NPU_HOST_POLL_TIMEOUT_EN
  localparam int PM = 8;
`else
  localparam int PM = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ena, wea;
  logic [15:0] addra;
  logic [31:0] dina;
  logic [31:0] douta = '0;
  logic [2:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  // bus monitor / model state (written only by the monitor process)
  int cyc = 0;
  int reads_5000 = 0;
  int reads_7000 = 0;
  int last_rd_cyc = 0;
  int trig_cnt = 0;
  int ena_back2back = 0;
  int wr_cnt = 0;
  logic ena_prev = 1'b0;
  // poll response script (written only by the initial block)
  int poll_base = 0;
  int poll_zero_n = 0;

  npu_host_seq #(.ADDR_W(16), .DATA_W(32), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // NPU model: douta registered one cycle after a read request
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ena_prev <= ena;
    if (ena && ena_prev) ena_back2back <= ena_back2back + 1;
    if (ena && wea) begin
      wr_cnt <= wr_cnt + 1;
      if (addra[14:12] == 3'd4 && dina[0]) trig_cnt <= trig_cnt + 1;
    end
    if (ena && !wea) begin
      if (addra == 16'h5000) begin
        reads_5000  <= reads_5000 + 1;
        last_rd_cyc <= cyc;
        douta <= ((reads_5000 - poll_base) < poll_zero_n) ? 32'h0 : 32'h1;
      end else if (addra == 16'h7000) begin
        reads_7000 <= reads_7000 + 1;
        douta <= 32'h1;
      end else begin
        douta <= 32'hdead_beef;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns just after the accepting clk edge
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_accept_bound", 32'(guard < 50), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit);
    int guard;
    guard = 0;
    while (!rsp_valid && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    chk("rsp_wait_bound", 32'(rsp_valid), 32'd1);
  endtask

  task automatic ack_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("ack_rsp_valid_low", 32'(rsp_valid), 32'd0);
    chk("ack_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  int start_cyc;
  int r0;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ena", 32'(ena), 32'd0);
    chk("rst_wea", 32'(wea), 32'd0);
    chk("rst_addra", 32'(addra), 32'd0);
    chk("rst_dina", dina, 32'd0);
    rst = 1'b0;

    // data-window write: single bus cycle, ready again next cycle
    issue(2'd0, 16'h1000, 32'h0003_0201);
    @(negedge clk);
    chk("wr_ena", 32'(ena), 32'd1);
    chk("wr_wea", 32'(wea), 32'd1);
    chk("wr_addra", 32'(addra), 32'h1000);
    chk("wr_dina", dina, 32'h0003_0201);
    chk("wr_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("wr_ena_off", 32'(ena), 32'd0);
    chk("wr_ready_back", 32'(cmd_ready), 32'd1);
    chk("wr_no_rsp", 32'(rsp_valid), 32'd0);

    // control write: bus cycle, gap cycle, then ready
    issue(2'd0, 16'h4000, 32'h1);
    @(negedge clk);
    chk("cw_ena", 32'(ena), 32'd1);
    chk("cw_addra", 32'(addra), 32'h4000);
    @(negedge clk);
    chk("cw_gap_ena", 32'(ena), 32'd0);
    chk("cw_gap_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("cw_ready_back", 32'(cmd_ready), 32'd1);
    chk("cw_trigger_once", 32'(trig_cnt), 32'd1);
    chk("cw_no_rsp", 32'(rsp_valid), 32'd0);

    // read: RD cycle, CAP cycle, response visible after the CAP edge
    issue(2'd1, 16'h7000, 32'h0);
    @(negedge clk);
    chk("rd_ena", 32'(ena), 32'd1);
    chk("rd_wea", 32'(wea), 32'd0);
    chk("rd_addra", 32'(addra), 32'h7000);
    @(negedge clk);
    chk("rd_cap_ena", 32'(ena), 32'd0);
    chk("rd_cap_novalid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_data", rsp_data, 32'h1);
    chk("rd_rsp_err", 32'(rsp_err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd_hold_valid", 32'(rsp_valid), 32'd1);
      chk("rd_hold_data", rsp_data, 32'h1);
      chk("rd_hold_no_ena", 32'(ena), 32'd0);
      chk("rd_hold_busy", 32'(cmd_ready), 32'd0);
    end
    ack_rsp();

    // reserved opcode behaves as a read
    issue(2'd3, 16'h7000, 32'h0);
    wait_rsp(10);
    chk("op3_data", rsp_data, 32'h1);
    ack_rsp();

    // poll: 4 misses then a hit, reads 2 cycles apart
    poll_base = reads_5000; poll_zero_n = 4;
    issue(2'd2, 16'h5000, 32'h1);
    start_cyc = cyc;
    wait_rsp(40);
    chk("poll_reads", 32'(reads_5000 - poll_base), 32'd5);
    chk("poll_span", 32'(last_rd_cyc - start_cyc), 32'd8);
    chk("poll_data", rsp_data, 32'h1);
    chk("poll_err", 32'(rsp_err), 32'd0);
    ack_rsp();

    // poll with empty mask: one read, immediate response
    poll_base = reads_5000; poll_zero_n = 3;
    issue(2'd2, 16'h5000, 32'h0);
    wait_rsp(10);
    chk("poll_m0_reads", 32'(reads_5000 - poll_base), 32'd1);
    chk("poll_m0_data", rsp_data, 32'h0);
    chk("poll_m0_err", 32'(rsp_err), 32'd0);
    ack_rsp();

    // poll that never matches
    poll_base = reads_5000; poll_zero_n = 100000;
    issue(2'd2, 16'h5000, 32'h1);
`ifdef NPU_HOST_POLL_TIMEOUT_EN
    wait_rsp(40);
    chk("poll_to_reads", 32'(reads_5000 - poll_base), 32'd8);
    chk("poll_to_err", 32'(rsp_err), 32'd1);
    chk("poll_to_data", rsp_data, 32'h0);
    ack_rsp();
`else
    repeat (100) @(negedge clk);
    chk("poll_inf_novalid", 32'(rsp_valid), 32'd0);
    chk("poll_inf_busy", 32'(cmd_ready), 32'd0);
    chk("poll_inf_reads", 32'((reads_5000 - poll_base) >= 45), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("poll_inf_abort_ready", 32'(cmd_ready), 32'd1);
`endif

    // reset asserted during CAP aborts the read
    r0 = reads_7000;
    issue(2'd1, 16'h7000, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ena", 32'(ena), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_one_read", 32'(reads_7000 - r0), 32'd1);
    issue(2'd1, 16'h7000, 32'h0);
    wait_rsp(10);
    chk("post_abort_data", rsp_data, 32'h1);
    ack_rsp();

    chk("ena_never_back2back", 32'(ena_back2back), 32'd0);
    chk("write_pulses", 32'(wr_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
